// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, active-video qualifier, syncs and
// line/frame pulses, all registered and cycle-aligned with DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VISIBLE  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       next_blank;
    logic       next_hs;
    logic       next_vs;
    logic       wrap_x;
    logic       wrap_frame;

    // With pix_en low the next state equals the current one, so every decode
    // derived from next_x/next_y naturally holds as well.
    always_comb begin
        next_x     = DrawX;
        next_y     = DrawY;
        wrap_x     = 1'b0;
        wrap_frame = 1'b0;
        if (pix_en) begin
            if (DrawX == H_LAST) begin
                next_x = 10'd0;
                wrap_x = 1'b1;
                if (DrawY == V_LAST) begin
                    next_y     = 10'd0;
                    wrap_frame = 1'b1;
                end else begin
                    next_y = DrawY + 10'd1;
                end
            end else begin
                next_x = DrawX + 10'd1;
            end
        end
    end

    always_comb begin
        next_blank = (next_x < H_VISIBLE) && (next_y < V_VISIBLE);
        next_hs    = ((next_x >= HS_FIRST) && (next_x <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        next_vs    = ((next_y >= VS_FIRST) && (next_y <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end

    // Reset parks the raster on the last pixel so the first advance lands on (0,0)
    // and produces the opening line/frame pulses.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            blank       <= 1'b0;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            DrawX       <= next_x;
            DrawY       <= next_y;
            blank       <= next_blank;
            hs          <= next_hs;
            vs          <= next_vs;
            line_start  <= wrap_x;
            frame_start <= wrap_frame;
            if (wrap_frame) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line-level
// timing and a tiny active-high-sync instance for frame-level behaviour.
module tb_vga_timing_gen;

    logic       vga_clk;
    logic       reset_b, pix_en_b;
    logic       reset_s, pix_en_s;

    logic [9:0] bx, by, sx, sy;
    logic       b_blank, b_hs, b_vs, b_ls, b_fs;
    logic       s_blank, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] b_fc, s_fc;

    int checkCount = 0;
    int passCount  = 0;

    vga_timing_gen dut (
        .vga_clk(vga_clk), .reset(reset_b), .pix_en(pix_en_b),
        .DrawX(bx), .DrawY(by), .blank(b_blank), .hs(b_hs), .vs(b_vs),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    // 15x8 raster: hsync on x 10..12, vsync on y 5..6, sync asserted high.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut_s (
        .vga_clk(vga_clk), .reset(reset_s), .pix_en(pix_en_s),
        .DrawX(sx), .DrawY(sy), .blank(s_blank), .hs(s_hs), .vs(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic checkBig(input string tag, input int x, input int y, input int bl,
                            input int h, input int v, input int ls, input int fs, input int fc);
        checkOutput({tag, ".x"},  32'(bx), 32'(x));
        checkOutput({tag, ".y"},  32'(by), 32'(y));
        checkOutput({tag, ".blank"}, 32'(b_blank), 32'(bl));
        checkOutput({tag, ".hs"}, 32'(b_hs), 32'(h));
        checkOutput({tag, ".vs"}, 32'(b_vs), 32'(v));
        checkOutput({tag, ".ls"}, 32'(b_ls), 32'(ls));
        checkOutput({tag, ".fs"}, 32'(b_fs), 32'(fs));
        checkOutput({tag, ".fc"}, 32'(b_fc), 32'(fc));
    endtask

    task automatic checkSmall(input string tag, input int x, input int y, input int bl,
                              input int h, input int v, input int ls, input int fs, input int fc);
        checkOutput({tag, ".x"},  32'(sx), 32'(x));
        checkOutput({tag, ".y"},  32'(sy), 32'(y));
        checkOutput({tag, ".blank"}, 32'(s_blank), 32'(bl));
        checkOutput({tag, ".hs"}, 32'(s_hs), 32'(h));
        checkOutput({tag, ".vs"}, 32'(s_vs), 32'(v));
        checkOutput({tag, ".ls"}, 32'(s_ls), 32'(ls));
        checkOutput({tag, ".fs"}, 32'(s_fs), 32'(fs));
        checkOutput({tag, ".fc"}, 32'(s_fc), 32'(fc));
    endtask

    initial begin
        int pulses;
        int lowPulses;
        int moved;

        reset_b  = 1'b1;
        pix_en_b = 1'b1;
        reset_s  = 1'b1;
        pix_en_s = 1'b0;

        // Default geometry: reset hold values and the first advancing edge.
        applyStimulus(3);
        checkBig("b_reset", 799, 524, 0, 1, 1, 0, 0, 0);
        reset_b = 1'b0;
        applyStimulus(1);
        checkBig("b_first", 0, 0, 1, 1, 1, 1, 1, 1);

        // One full line: blank edge, hsync window, line wrap.
        applyStimulus(639);
        checkBig("b_x639", 639, 0, 1, 1, 1, 0, 0, 1);
        applyStimulus(1);
        checkBig("b_x640", 640, 0, 0, 1, 1, 0, 0, 1);
        applyStimulus(15);
        checkBig("b_x655", 655, 0, 0, 1, 1, 0, 0, 1);
        applyStimulus(1);
        checkBig("b_x656", 656, 0, 0, 0, 1, 0, 0, 1);
        applyStimulus(95);
        checkBig("b_x751", 751, 0, 0, 0, 1, 0, 0, 1);
        applyStimulus(1);
        checkBig("b_x752", 752, 0, 0, 1, 1, 0, 0, 1);
        applyStimulus(47);
        checkBig("b_x799", 799, 0, 0, 1, 1, 0, 0, 1);
        applyStimulus(1);
        checkBig("b_wrap", 0, 1, 1, 1, 1, 1, 0, 1);
        applyStimulus(1);
        checkBig("b_x1", 1, 1, 1, 1, 1, 0, 0, 1);

        // A stalled edge holds everything.
        pix_en_b = 1'b0;
        applyStimulus(1);
        checkBig("b_stall", 1, 1, 1, 1, 1, 0, 0, 1);
        pix_en_b = 1'b1;
        applyStimulus(299);
        checkBig("b_x300", 300, 1, 1, 1, 1, 0, 0, 1);

        // Mid-line reset must act before the next clock edge.
        #3 reset_b = 1'b1;
        #1 checkBig("b_async", 799, 524, 0, 1, 1, 0, 0, 0);
        reset_b = 1'b0;
        applyStimulus(1);
        checkBig("b_restart", 0, 0, 1, 1, 1, 1, 1, 1);

        // Park the default instance and move to the small raster.
        reset_b  = 1'b1;
        checkSmall("s_reset", 14, 7, 0, 0, 0, 0, 0, 0);
        reset_s  = 1'b0;
        pix_en_s = 1'b1;
        applyStimulus(1);
        checkSmall("s_first", 0, 0, 1, 0, 0, 1, 1, 1);
        applyStimulus(7);
        checkSmall("s_x7", 7, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(1);
        checkSmall("s_x8", 8, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(2);
        checkSmall("s_x10", 10, 0, 0, 1, 0, 0, 0, 1);
        applyStimulus(2);
        checkSmall("s_x12", 12, 0, 0, 1, 0, 0, 0, 1);
        applyStimulus(1);
        checkSmall("s_x13", 13, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(2);
        checkSmall("s_y1", 0, 1, 1, 0, 0, 1, 0, 1);
        applyStimulus(45);
        checkSmall("s_y4", 0, 4, 0, 0, 0, 1, 0, 1);
        applyStimulus(15);
        checkSmall("s_y5", 0, 5, 0, 0, 1, 1, 0, 1);
        applyStimulus(15);
        checkSmall("s_y6", 0, 6, 0, 0, 1, 1, 0, 1);
        applyStimulus(15);
        checkSmall("s_y7", 0, 7, 0, 0, 0, 1, 0, 1);
        applyStimulus(14);
        checkSmall("s_last", 14, 7, 0, 0, 0, 0, 0, 1);
        applyStimulus(1);
        checkSmall("s_frame2", 0, 0, 1, 0, 0, 1, 1, 2);

        // Exactly one frame_start per 120-clock frame.
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1);
            if (s_fs) pulses++;
        end
        checkOutput("s_frame_pulses", 32'(pulses), 32'd1);
        checkOutput("s_fc3", 32'(s_fc), 32'd3);

        // Half-duty pix_en: one advance per two clocks, no pulse on stalled edges.
        pulses    = 0;
        lowPulses = 0;
        for (int i = 0; i < 30; i++) begin
            pix_en_s = 1'b0;
            applyStimulus(1);
            if (s_ls || s_fs) lowPulses++;
            pix_en_s = 1'b1;
            applyStimulus(1);
            if (s_ls) pulses++;
        end
        checkOutput("s_half_low_pulses", 32'(lowPulses), 32'd0);
        checkOutput("s_half_ls_count", 32'(pulses), 32'd2);
        checkSmall("s_half_end", 0, 2, 1, 0, 0, 1, 0, 3);

        // Stall across the frame wrap for 5 clocks.
        applyStimulus(89);
        checkSmall("s_prewrap", 14, 7, 0, 0, 0, 0, 0, 3);
        pix_en_s  = 1'b0;
        lowPulses = 0;
        moved     = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            if (s_ls || s_fs) lowPulses++;
            if (sx != 10'd14 || sy != 10'd7) moved++;
        end
        checkOutput("s_stall_pulses", 32'(lowPulses), 32'd0);
        checkOutput("s_stall_moved", 32'(moved), 32'd0);
        pix_en_s = 1'b1;
        applyStimulus(1);
        checkSmall("s_deferred_wrap", 0, 0, 1, 0, 0, 1, 1, 4);
        applyStimulus(1);
        checkSmall("s_after_wrap", 1, 0, 1, 0, 0, 0, 0, 4);

        // frame_count rollover 255 -> 0.
        applyStimulus(119 + 250 * 120);
        checkOutput("s_fc255", 32'(s_fc), 32'd255);
        applyStimulus(120);
        checkSmall("s_fc_wrap", 0, 0, 1, 0, 0, 1, 1, 0);

        // Mid-frame asynchronous reset and clean restart.
        applyStimulus(37);
        checkOutput("s_mid_x", 32'(sx), 32'd7);
        #3 reset_s = 1'b1;
        #1 checkSmall("s_async", 14, 7, 0, 0, 0, 0, 0, 0);
        reset_s = 1'b0;
        applyStimulus(1);
        checkSmall("s_restart", 0, 0, 1, 0, 0, 1, 1, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates the raster timing that drives every sprite/ROM pixel pipeline in the display path.
- Produces horizontal and vertical counters (DrawX, DrawY), the active-video qualifier (blank, high = visible), hsync/vsync, and per-line and per-frame pulses.
- Sprite renderers consume DrawX/DrawY/blank on the same vga_clk; hs/vs go straight to the connector.
- Default geometry is 640x480 at 60 Hz (800x525 total).

## Interface

Parameters:

- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports (one clock; reset is asynchronous and active-high):

- vga_clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel advance enable; tie high for one pixel per clock
- DrawX  out  10  horizontal counter, 0..H_TOTAL-1
- DrawY  out  10  vertical counter, 0..V_TOTAL-1
- blank  out  1  1 when DrawX<H_ACTIVE and DrawY<V_ACTIVE
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- line_start  out  1  one-cycle pulse when DrawX becomes 0
- frame_start  out  1  one-cycle pulse when (DrawX,DrawY) becomes (0,0)
- frame_count  out  8  completed-frame counter, wraps 255->0

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Region order on each axis: active, front porch, sync, back porch.
- On a vga_clk rising edge with pix_en=1:
  - If DrawX = H_TOTAL-1, DrawX goes to 0 and DrawY advances: DrawY = V_TOTAL-1 wraps to 0, otherwise DrawY+1.
  - Otherwise DrawX+1 and DrawY holds.
- On a vga_clk rising edge with pix_en=0: counters, hs, vs, blank and frame_count all hold. line_start and frame_start are forced to 0.
- hs = SYNC_POL when DrawX is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); otherwise ~SYNC_POL.
- vs = SYNC_POL when DrawY is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491); otherwise ~SYNC_POL.
- blank, hs and vs are registered. Each is computed from the next-state counter values, so all three are cycle-aligned with the DrawX/DrawY they describe. There is no one-pixel skew.
- line_start = 1 for exactly the cycle in which the registered DrawX is 0, and only when that 0 was reached by an advancing edge.
- frame_start = 1 for exactly the cycle in which the registered (DrawX,DrawY) is (0,0), under the same advancing-edge condition.
- frame_count increments, modulo 256, on the same edge that raises frame_start.
- Counter arithmetic is unsigned, 10 bits. Parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024. This is not checked in RTL.

## Timing

Reset (asynchronous, takes effect immediately, held while high):

- DrawX = H_TOTAL-1 (799), DrawY = V_TOTAL-1 (524)
- blank=0, hs=vs=~SYNC_POL (1), line_start=0, frame_start=0, frame_count=0

After reset:

- The first advancing edge after deassertion yields DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=1.
- Latency from counter to outputs is 0: outputs and counters update on the same edge.
- Downstream ROM readers use negedge sampling, so DrawX/DrawY must be glitch-free flops, with no combinational decode on the outputs.
- Frame period with pix_en=1: 420000 clocks. Line period: 800 clocks.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. There is no partial-line continuation.
- pix_en low on the wrap edge: the wrap is deferred to the next edge with pix_en=1, and the pulses fire then.

## Test plan

- Reset, then release with pix_en=1 → the held values are exactly (799,524,blank=0,hs=1,vs=1,frame_count=0). The first edge gives (0,0), blank=1, line_start=1, frame_start=1, frame_count=1.
- Run one line → blank falls as DrawX goes 639->640. hs goes low at DrawX=656 and high at DrawX=752. At 799->0, DrawY goes 0->1 and line_start pulses exactly one cycle.
- Run one full frame → blank stays 0 for DrawY 480..524. vs is low for DrawY 490..491 only. Exactly one frame_start pulse occurs per 420000 clocks, and frame_count goes 1->2.
- Toggle pix_en at 1/2 duty → every output advances once per two clocks. Pulses last one clock and never stretch while pix_en=0.
- Hold pix_en=0 across the (799,524) edge for 5 clocks → no wrap, no pulses. The next pix_en=1 edge gives (0,0) with a single frame_start.
- Assert reset at DrawX=300, DrawY=200 → outputs become reset values before the next edge. Restart follows the first scenario exactly.
- Preset frame_count to 255 by running 255 frames → the next wrap gives frame_count=0.
